// File: rtl/msb_scan_ctrl.sv
// msb_scan_ctrl: accepts one N-bit word, then emits the indices of its set
// bits from highest to lowest, one per output handshake.
// Optional feature: define MSB_SCAN_COUNT_EN to add out_cnt, the 0-based
// beat index within the current word.
module msb_scan_ctrl #(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_word,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pos,
  output logic         out_last,
  output logic         out_zero,
  input  logic         abort
`ifdef MSB_SCAN_COUNT_EN
  ,
  output logic [W:0]   out_cnt
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state, state_nx;
  logic [N-1:0] work;
  logic [N-1:0] top_onehot;
  logic [W-1:0] top_pos;
  logic         zero_flag;
  logic         single;
  logic         accept;
  logic         fire;

  // Priority encoder: last assignment wins, so the highest set bit is kept
  always_comb begin
    top_pos    = '0;
    top_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (work[i]) begin
        top_pos       = W'(i);
        top_onehot    = '0;
        top_onehot[i] = 1'b1;
      end
    end
  end

  // At most one bit left (also true for an all-zero word)
  assign single = ((work & (work - N'(1))) == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_pos   = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    accept    = 1'b0;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !abort) begin
          accept   = 1'b1;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_pos   = top_pos;
        out_last  = single;
        out_zero  = zero_flag;
        if (abort) begin
          state_nx = IDLE;
        end else if (out_ready) begin
          fire = 1'b1;
          if (single) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Working word, zero flag and optional beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      zero_flag <= 1'b0;
`ifdef MSB_SCAN_COUNT_EN
      out_cnt   <= '0;
`endif
    end else if (accept) begin
      work      <= in_word;
      zero_flag <= (in_word == '0);
`ifdef MSB_SCAN_COUNT_EN
      out_cnt   <= '0;
`endif
    end else if (state == SCAN && abort) begin
      work <= '0;
    end else if (fire) begin
      work <= work & ~top_onehot;
`ifdef MSB_SCAN_COUNT_EN
      out_cnt <= out_cnt + (W+1)'(1);
`endif
    end
  end

endmodule

// File: tb/tb_msb_scan_ctrl.sv
// tb_msb_scan_ctrl: directed stimulus against a queue-based model of the
// bit-scan sequencer, plus literal checks of emitted sequences.
module tb_msb_scan_ctrl;
  localparam int N = 64;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, abort;
  logic [N-1:0] in_word;
  logic         in_ready, out_valid, out_last, out_zero;
  logic [W-1:0] out_pos;
`ifdef MSB_SCAN_COUNT_EN
  logic [W:0]   out_cnt;
`endif

  msb_scan_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .out_last(out_last), .out_zero(out_zero),
    .abort(abort)
`ifdef MSB_SCAN_COUNT_EN
    , .out_cnt(out_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: list of positions still to be emitted for the current word
  bit busy = 0;
  bit m_zero = 0;
  int m_cnt = 0;
  int q[$];
  int log_q[$];

  function automatic void check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void check_seq(string nm, int exp[$]);
    check({nm, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check(nm, log_q[i], exp[i]);
    log_q.delete();
  endfunction

  function automatic void model_step(bit rs, bit iv, logic [N-1:0] iw, bit ordy, bit ab);
    if (rs) begin
      busy = 0; q.delete(); m_zero = 0; m_cnt = 0;
    end else if (!busy) begin
      if (iv && !ab) begin
        q.delete();
        for (int b = N - 1; b >= 0; b--) if (iw[b]) q.push_back(b);
        m_zero = (q.size() == 0);
        if (m_zero) q.push_back(0);
        busy = 1; m_cnt = 0;
      end
    end else if (ab) begin
      busy = 0; q.delete();
    end else if (ordy) begin
      void'(q.pop_front());
      m_cnt++;
      if (q.size() == 0) busy = 0;
    end
  endfunction

  // One cycle: compare at negedge, drive inputs, advance model at posedge
  task automatic cyc(bit rs, bit iv, logic [N-1:0] iw, bit ordy, bit ab);
    check("in_ready", in_ready, !busy);
    check("out_valid", out_valid, busy);
    check("out_pos", out_pos, busy ? q[0] : 0);
    check("out_last", out_last, busy && q.size() == 1);
    check("out_zero", out_zero, busy && m_zero);
`ifdef MSB_SCAN_COUNT_EN
    check("out_cnt", out_cnt, m_cnt);
`endif
    if (busy && ordy && !ab && !rs) log_q.push_back(int'(out_pos));
    rst = rs; in_valid = iv; in_word = iw; out_ready = ordy; abort = ab;
    @(posedge clk);
    model_step(rs, iv, iw, ordy, ab);
    @(negedge clk);
  endtask

  task automatic run_word(logic [N-1:0] w, int beats);
    cyc(0, 1, w, 1, 0);
    for (int i = 0; i < beats; i++) cyc(0, 1, 64'hFFFF, 1, 0);
    cyc(0, 0, '0, 1, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_word = '0; out_ready = 0; abort = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    cyc(1, 0, '0, 0, 0);

    run_word(64'h3131, 6);
    check_seq("seq_3131", '{13, 12, 8, 5, 4, 0});

    run_word(64'h3100000000003131, 9);
    check_seq("seq_long", '{61, 60, 56, 13, 12, 8, 5, 4, 0});

    cyc(0, 1, 64'h1, 1, 0);
    check("one_last", out_last, 1);
    check("one_zero", out_zero, 0);
    cyc(0, 0, '0, 1, 0);
    cyc(0, 1, 64'h0, 1, 0);
    check("zero_flag", out_zero, 1);
    check("zero_last", out_last, 1);
    cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 1, 0);
    check_seq("seq_one_zero", '{0, 0});

    // abort in idle wins over in_valid
    cyc(0, 1, 64'h5, 1, 1);
    check("abort_idle", out_valid, 0);

    // backpressure
    cyc(0, 1, 64'h3131, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", out_pos, 13);
      cyc(0, 0, '0, 0, 0);
    end
    check("bp_hold", out_pos, 13);
    for (int i = 0; i < 6; i++) cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 1, 0);
    check_seq("seq_bp", '{13, 12, 8, 5, 4, 0});

    // abort while pos 8 shown
    cyc(0, 1, 64'h3131, 1, 0);
    cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 1, 0);
    check("abort_at8", out_pos, 8);
    cyc(0, 0, '0, 1, 1);
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    check_seq("seq_abort", '{13, 12});
    run_word(64'h1, 1);
    check_seq("seq_after_abort", '{0});

    // reset while pos 5 shown
    cyc(0, 1, 64'h3131, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 0);
    check("rst_at5", out_pos, 5);
    cyc(1, 0, '0, 1, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_pos", out_pos, 0);
    check("rst_mid_last", out_last, 0);
    check("rst_mid_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 0);
    check_seq("seq_rst", '{13, 12, 8});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
